unified_mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the Fetch stage (IF port) and the Memory stage (DM port) of the pipelined RV32I core.
- Sequences one memory transaction at a time and returns the data to the owning requester.
- Generates per-port stall requests. These are ORed into StallF/StallD (IF) and a full-pipeline stall (DM) alongside the hazard unit outputs.
- Handles fetch kills caused by taken branches (PCSrcE).

---
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/DM arbiter for a single-port unified memory.
// Optional MEM_ARB_PERF_EN adds conflict and stall performance counters.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   input  logic                    if_kill_i,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   output logic                    if_valid_o,
   input  logic                    dm_req_i,
   input  logic                    dm_we_i,
   input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
   input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] dm_be_i,
   output logic [DATA_WIDTH-1:0]   dm_rdata_o,
   output logic                    dm_valid_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    stall_if_o,
   output logic                    stall_dm_o
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]             perf_conflict_o,
   output logic [31:0]             perf_stall_o
`endif
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;
   typedef enum logic {OWNER_IF, OWNER_DM} owner_t;

   state_t                  state_q, state_d;
   owner_t                  owner_q, owner_d;
   logic                    kill_q, kill_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [BE_WIDTH-1:0]     be_q, be_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= OWNER_IF;
         kill_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         kill_q  <= kill_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      kill_d     = kill_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_valid_o = 1'b0;
      if_rdata_o = '0;
      dm_valid_o = 1'b0;
      dm_rdata_o = '0;
      case (state_q)
         IDLE: begin
            // DM belongs to the older instruction, so it always wins
            if (dm_req_i) begin
               owner_d = OWNER_DM;
               we_d    = dm_we_i;
               addr_d  = dm_addr_i;
               wdata_d = dm_we_i ? dm_wdata_i : '0;
               be_d    = dm_we_i ? dm_be_i : {BE_WIDTH{1'b1}};
               state_d = WAIT_GNT;
            end else if (if_req_i && !if_kill_i) begin
               owner_d = OWNER_IF;
               we_d    = 1'b0;
               addr_d  = if_addr_i;
               wdata_d = '0;
               be_d    = {BE_WIDTH{1'b1}};
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (if_kill_i && owner_q == OWNER_IF) kill_d = 1'b1;
            if (mem_gnt_i) state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (if_kill_i && owner_q == OWNER_IF) kill_d = 1'b1;
            if (mem_rvalid_i) begin
               state_d = IDLE;
               kill_d  = 1'b0;
               if (owner_q == OWNER_DM) begin
                  dm_valid_o = 1'b1;
                  dm_rdata_o = mem_rdata_i;
               end else if (!kill_q && !if_kill_i) begin
                  if_valid_o = 1'b1;
                  if_rdata_o = mem_rdata_i;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_req_o   = (state_q == WAIT_GNT);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;

   // a kill redirects the PC, so the fetch side must not hold on that cycle
   assign stall_if_o = if_req_i && !if_valid_o && !if_kill_i;
   assign stall_dm_o = dm_req_i && !dm_valid_o;

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_conflict_o <= '0;
         perf_stall_o    <= '0;
      end else begin
         if (state_q == IDLE && if_req_i && dm_req_i) perf_conflict_o <= perf_conflict_o + 32'd1;
         if (stall_if_o || stall_dm_o) perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - testbench for unified_mem_arbiter
module tb_unified_mem_arbiter;
   localparam int MEM_WORDS = 4096;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        if_req_i = 1'b0, if_kill_i = 1'b0, if_valid_o;
   logic [31:0] if_addr_i = '0, if_rdata_o;
   logic        dm_req_i = 1'b0, dm_we_i = 1'b0, dm_valid_o;
   logic [31:0] dm_addr_i = '0, dm_wdata_i = '0, dm_rdata_o;
   logic [3:0]  dm_be_i = '0;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        stall_if_o, stall_dm_o;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_conflict_o, perf_stall_o;
`endif

   int vectors = 0;
   int errors  = 0;

   logic [31:0] ref_mem   [MEM_WORDS];
   logic [31:0] slave_mem [MEM_WORDS];

   bit          slave_en = 1'b0, slave_rand = 1'b0, rsp_pending = 1'b0, snap_valid = 1'b0;
   int          gnt_delay = 0, rsp_delay = 0, gnt_cnt = 0, rsp_cnt = 0;
   logic [31:0] rsp_data;
   logic [68:0] snap;
   logic [31:0] gnt_log[$];

   unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
      .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
      .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o)
`ifdef MEM_ARB_PERF_EN
      , .perf_conflict_o(perf_conflict_o), .perf_stall_o(perf_stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // memory slave: grants after a delay, answers from its own copy of memory
   initial begin
      logic [11:0] idx;
      forever begin
         @(posedge clk_i); #1;
         if (slave_en) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (rsp_pending) begin
               if (rsp_cnt == 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = rsp_data;
                  rsp_pending  = 1'b0;
               end else rsp_cnt--;
            end else if (mem_req_o) begin
               vectors++;
               if (snap_valid) begin
                  if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== snap) begin
                     errors++;
                     $display("FAIL req_stable: got %h required %h",
                              {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, snap);
                  end
               end else begin
                  snap = {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
                  snap_valid = 1'b1;
                  if (!mem_we_o && mem_be_o !== 4'hF) begin
                     errors++;
                     $display("FAIL read_be: got %h required f", mem_be_o);
                  end
               end
               if (gnt_cnt == 0) begin
                  mem_gnt_i  = 1'b1;
                  snap_valid = 1'b0;
                  gnt_log.push_back(mem_addr_o);
                  idx = mem_addr_o[13:2];
                  if (mem_we_o) slave_mem[idx] = merge(slave_mem[idx], mem_wdata_o, mem_be_o);
                  rsp_data    = mem_we_o ? 32'h0 : slave_mem[idx];
                  rsp_pending = 1'b1;
                  rsp_cnt = slave_rand ? int'($urandom_range(0, 3)) : rsp_delay;
                  gnt_cnt = slave_rand ? int'($urandom_range(0, 3)) : gnt_delay;
               end else gnt_cnt--;
            end
         end
      end
   end

   task automatic slave_reset(input int g, input int r);
      gnt_delay = g; rsp_delay = r; gnt_cnt = g;
      rsp_pending = 1'b0; snap_valid = 1'b0;
      gnt_log.delete();
   endtask

   task automatic apply_reset();
      slave_en = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if_req_i = 1'b0; if_kill_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      slave_reset(0, 0);
      slave_en = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      slave_en = 1'b0;
      @(negedge clk_i);
      vectors++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_valid_o, dm_valid_o,
           stall_if_o, stall_dm_o, if_rdata_o, dm_rdata_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b addr=%h be=%h ifv=%b dmv=%b required all 0",
                  mem_req_o, mem_addr_o, mem_be_o, if_valid_o, dm_valid_o);
      end
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
      @(negedge clk_i);
      vectors++;
      if ({if_valid_o, dm_valid_o, mem_req_o} !== 3'b000) begin
         errors++;
         $display("FAIL unsolicited_rvalid: got ifv/dmv/req=%b required 000",
                  {if_valid_o, dm_valid_o, mem_req_o});
      end
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      slave_reset(0, 0);
      slave_en = 1'b1;
   endtask

   task automatic test_lone_fetch();
      slave_reset(0, 0);
      @(posedge clk_i); #1;
      if_addr_i = 32'h100; if_req_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({stall_if_o, if_valid_o, mem_req_o} !== 3'b100) begin
         errors++;
         $display("FAIL fetch_c1: got stall/valid/req=%b required 100", {stall_if_o, if_valid_o, mem_req_o});
      end
      @(negedge clk_i);
      vectors++;
      if ({stall_if_o, mem_req_o, mem_addr_o} !== {2'b11, 32'h100}) begin
         errors++;
         $display("FAIL fetch_c2: got stall=%b req=%b addr=%h required 1 1 100",
                  stall_if_o, mem_req_o, mem_addr_o);
      end
      @(negedge clk_i);
      vectors++;
      if ({if_valid_o, stall_if_o, if_rdata_o} !== {2'b10, 32'h00500093}) begin
         errors++;
         $display("FAIL fetch_c3: got valid=%b stall=%b data=%h required 1 0 00500093",
                  if_valid_o, stall_if_o, if_rdata_o);
      end
      @(posedge clk_i); #1;
      if_req_i = 1'b0;
   endtask

   task automatic test_simultaneous();
      int n, n_dm, n_if, bad_stall;
      bit drop_dm;
      slave_reset(0, 0);
      n = 0; n_dm = -1; n_if = -1; bad_stall = 0; drop_dm = 1'b0;
      @(posedge clk_i); #1;
      if_addr_i = 32'h104; if_req_i = 1'b1;
      dm_addr_i = 32'h2000; dm_we_i = 1'b0; dm_be_i = 4'h0; dm_req_i = 1'b1;
      while (n_if < 0 && n < 40) begin
         @(negedge clk_i);
         n++;
         if (!if_valid_o && !stall_if_o) bad_stall++;
         if (dm_valid_o) begin
            n_dm = n; drop_dm = 1'b1;
            vectors++;
            if (dm_rdata_o !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL sim_dm_data: got %h required deadbeef", dm_rdata_o);
            end
         end
         if (if_valid_o) begin
            n_if = n;
            vectors++;
            if (if_rdata_o !== ref_mem[32'h104 >> 2]) begin
               errors++;
               $display("FAIL sim_if_data: got %h required %h", if_rdata_o, ref_mem[32'h104 >> 2]);
            end
         end
         @(posedge clk_i); #1;
         if (drop_dm) begin dm_req_i = 1'b0; drop_dm = 1'b0; end
      end
      if_req_i = 1'b0;
      vectors++;
      if (n_dm != 3 || n_if != n_dm + 3) begin
         errors++;
         $display("FAIL sim_timing: got dm_valid cycle %0d if_valid cycle %0d required 3 and 6", n_dm, n_if);
      end
      vectors++;
      if (gnt_log.size() != 2 || gnt_log[0] !== 32'h2000 || gnt_log[1] !== 32'h104) begin
         errors++;
         $display("FAIL sim_order: got %0d grants first %h required 2000 then 104",
                  gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 32'hx);
      end
      vectors++;
      if (bad_stall != 0) begin
         errors++;
         $display("FAIL sim_stall_if: got %0d unstalled cycles required 0", bad_stall);
      end
   endtask

   task automatic test_store_delay();
      int n, req_cycles, bad;
      bit got;
      slave_reset(3, 0);
      n = 0; req_cycles = 0; bad = 0; got = 1'b0;
      @(posedge clk_i); #1;
      dm_addr_i = 32'h3000; dm_we_i = 1'b1; dm_wdata_i = 32'h12345678; dm_be_i = 4'b0011; dm_req_i = 1'b1;
      while (!got && n < 40) begin
         @(negedge clk_i);
         n++;
         if (mem_req_o) begin
            req_cycles++;
            if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {1'b1, 32'h3000, 32'h12345678, 4'b0011}) bad++;
         end
         if (dm_valid_o) got = 1'b1;
      end
      @(posedge clk_i); #1;
      dm_req_i = 1'b0;
      vectors++;
      if (!got || req_cycles != 4 || bad != 0) begin
         errors++;
         $display("FAIL store_delay: got valid=%b req_cycles=%0d bad=%0d required 1 4 0", got, req_cycles, bad);
      end
      ref_mem[32'h3000 >> 2] = merge(ref_mem[32'h3000 >> 2], 32'h12345678, 4'b0011);
      slave_reset(0, 1);
      dm_we_i = 1'b0; dm_req_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!dm_valid_o && n < 40);
      vectors++;
      if (!dm_valid_o || dm_rdata_o !== ref_mem[32'h3000 >> 2]) begin
         errors++;
         $display("FAIL store_readback: got valid=%b data=%h required %h", dm_valid_o, dm_rdata_o,
                  ref_mem[32'h3000 >> 2]);
      end
      @(posedge clk_i); #1;
      dm_req_i = 1'b0;
   endtask

   task automatic test_kill();
      int n;
      slave_reset(0, 2);
      @(posedge clk_i); #1;
      if_addr_i = 32'h180; if_req_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!mem_req_o && n < 10);
      do begin @(negedge clk_i); n++; end while (mem_req_o && n < 20);
      @(posedge clk_i); #1;
      if_kill_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({stall_if_o, if_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL kill_cycle: got stall/valid=%b required 00", {stall_if_o, if_valid_o});
      end
      @(posedge clk_i); #1;
      if_kill_i = 1'b0; if_addr_i = 32'h200;
      @(negedge clk_i);
      vectors++;
      if ({mem_rvalid_i, if_valid_o} !== 2'b10) begin
         errors++;
         $display("FAIL kill_suppress: got rvalid/valid=%b required 10", {mem_rvalid_i, if_valid_o});
      end
      n = 0;
      do begin @(negedge clk_i); n++; end while (!if_valid_o && n < 40);
      vectors++;
      if (!if_valid_o || if_rdata_o !== ref_mem[32'h200 >> 2] || gnt_log.size() != 2 || gnt_log[1] !== 32'h200) begin
         errors++;
         $display("FAIL kill_refetch: got valid=%b data=%h grants=%0d required 1 %h 2",
                  if_valid_o, if_rdata_o, gnt_log.size(), ref_mem[32'h200 >> 2]);
      end
      @(posedge clk_i); #1;
      if_req_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      slave_en = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
      if_addr_i = 32'h40; if_req_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      vectors++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: got mem_req=%b required 1", mem_req_o);
      end
      rst_ni = 1'b0;
      #1;
      vectors++;
      if ({mem_req_o, if_valid_o, dm_valid_o} !== 3'b000) begin
         errors++;
         $display("FAIL rst_async: got req/ifv/dmv=%b required 000", {mem_req_o, if_valid_o, dm_valid_o});
      end
      if_req_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
      @(posedge clk_i); #2;
      rst_ni = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({mem_req_o, if_valid_o, dm_valid_o} !== 3'b000) begin
         errors++;
         $display("FAIL rst_late_rvalid: got req/ifv/dmv=%b required 000", {mem_req_o, if_valid_o, dm_valid_o});
      end
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      slave_reset(0, 0);
      slave_en = 1'b1;
   endtask

   task automatic test_random();
      slave_reset(0, 0);
      slave_rand = 1'b1;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               int n, bad;
               logic [31:0] a;
               repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
               a = 32'($urandom_range(0, 1023)) << 2;
               if_addr_i = a; if_req_i = 1'b1;
               n = 0; bad = 0;
               do begin
                  @(negedge clk_i); n++;
                  if (stall_if_o !== !if_valid_o) bad++;
               end while (!if_valid_o && n < 200);
               vectors++;
               if (!if_valid_o || if_rdata_o !== ref_mem[a[13:2]] || bad != 0) begin
                  errors++;
                  $display("FAIL rand_fetch %h: got valid=%b data=%h stall_err=%0d required %h",
                           a, if_valid_o, if_rdata_o, bad, ref_mem[a[13:2]]);
               end
               @(posedge clk_i); #1;
               if_req_i = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 30; i++) begin
               int n;
               logic [31:0] a, wd;
               logic [3:0] be;
               logic we;
               repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
               a = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
               wd = $urandom; be = 4'($urandom_range(0, 15)); we = 1'($urandom_range(0, 1));
               dm_addr_i = a; dm_wdata_i = wd; dm_be_i = be; dm_we_i = we; dm_req_i = 1'b1;
               n = 0;
               do begin @(negedge clk_i); n++; end while (!dm_valid_o && n < 200);
               vectors++;
               if (!dm_valid_o || (!we && dm_rdata_o !== ref_mem[a[13:2]])) begin
                  errors++;
                  $display("FAIL rand_dm %h we=%b: got valid=%b data=%h required %h",
                           a, we, dm_valid_o, dm_rdata_o, ref_mem[a[13:2]]);
               end
               if (we) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], wd, be);
               @(posedge clk_i); #1;
               dm_req_i = 1'b0;
            end
         end
      join
      slave_rand = 1'b0;
   endtask

`ifdef MEM_ARB_PERF_EN
   task automatic test_perf();
      apply_reset();
      @(negedge clk_i);
      vectors++;
      if ({perf_conflict_o, perf_stall_o} !== 64'h0) begin
         errors++;
         $display("FAIL perf_reset: got %h %h required 0 0", perf_conflict_o, perf_stall_o);
      end
      for (int r = 0; r < 4; r++) test_simultaneous();
      @(negedge clk_i);
      vectors++;
      if (perf_conflict_o !== 32'd4 || perf_stall_o !== 32'd20) begin
         errors++;
         $display("FAIL perf_count: got conflict=%0d stall=%0d required 4 20", perf_conflict_o, perf_stall_o);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      ref_mem[32'h100 >> 2]  = 32'h00500093;
      ref_mem[32'h2000 >> 2] = 32'hDEADBEEF;
      ref_mem[32'h200 >> 2]  = 32'h00A00113;
      for (int i = 0; i < MEM_WORDS; i++) slave_mem[i] = ref_mem[i];
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_store_delay();
      test_kill();
      test_reset_mid();
      test_random();
`ifdef MEM_ARB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
